// File: rtl/dino_pkg.sv
// Shared constants and the game state encoding for the dino game monitor.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_state_t;

  localparam int SCREEN_WIDTH = 640;
  localparam int GROUND_LINE  = 440;
  localparam int DINO_WIDTH   = 40;
  localparam int DINO_HEIGHT  = 43;

endpackage

// File: rtl/game_monitor_if.sv
// Player/obstacle inputs and score outputs of the game monitor.
interface game_monitor_if;

  logic        start;
  logic [9:0]  obstacle_h;
  logic [9:0]  obstacle_v;
  logic [7:0]  obstacle_width;
  logic [7:0]  obstacle_height;
  logic [9:0]  dino_h;
  logic [9:0]  dino_v;
  logic [1:0]  game_state;
  logic        hit;
  logic [15:0] score;
  logic [15:0] high_score;
  logic [7:0]  obstacles_passed;

  modport master (
    output start, obstacle_h, obstacle_v, obstacle_width, obstacle_height, dino_h, dino_v,
    input  game_state, hit, score, high_score, obstacles_passed
  );

  modport slave (
    input  start, obstacle_h, obstacle_v, obstacle_width, obstacle_height, dino_h, dino_v,
    output game_state, hit, score, high_score, obstacles_passed
  );

endinterface

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter that saturates at 9999; clr takes priority over inc.
module bcd_counter4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] nxt;
  logic        carry;

  always_comb begin
    nxt   = value;
    carry = 1'b1;
    if (value != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (value[4*i +: 4] == 4'd9) begin
            nxt[4*i +: 4] = 4'd0;
          end else begin
            nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
            carry         = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= 16'h0000;
    end else if (clr) begin
      value <= 16'h0000;
    end else if (inc) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/game_monitor.sv
// Game monitor: collision detection, run/over sequencing, BCD score, high score
// and obstacle pass counting.
module game_monitor #(
  parameter int SCREEN_WIDTH = dino_pkg::SCREEN_WIDTH,
  parameter int DINO_WIDTH   = dino_pkg::DINO_WIDTH,
  parameter int DINO_HEIGHT  = dino_pkg::DINO_HEIGHT,
  parameter int SCORE_DIV    = 8
) (
  input  logic           clk,
  input  logic           rst,
  game_monitor_if.slave  bus
);

  import dino_pkg::*;

  localparam logic [10:0] WRAP_LIMIT = 11'(SCREEN_WIDTH + 64);
  localparam logic [10:0] SCREEN_LIM = 11'(SCREEN_WIDTH);
  localparam logic [10:0] DW         = 11'(DINO_WIDTH);
  localparam logic [10:0] DH         = 11'(DINO_HEIGHT);
  localparam logic [7:0]  DIV_LAST   = 8'(SCORE_DIV - 1);

  game_state_t state;
  logic        hit;
  logic        start_q;
  logic        armed;
  logic [7:0]  div;
  logic [7:0]  passed;
  logic [15:0] score;
  logic [15:0] high_score;

  logic [10:0] oh, ow, ov, oht, dh, dv;
  logic [10:0] obs_left, obs_bot, dino_right, dino_bot;
  logic        collision, start_edge, in_run, tick, score_inc, score_clr;
  logic        pass, rearm;

  assign oh  = {1'b0, bus.obstacle_h};
  assign ow  = {3'b000, bus.obstacle_width};
  assign ov  = {1'b0, bus.obstacle_v};
  assign oht = {3'b000, bus.obstacle_height};
  assign dh  = {1'b0, bus.dino_h};
  assign dv  = {1'b0, bus.dino_v};

  assign obs_left   = (ow > oh) ? 11'd0 : oh - ow;
  assign obs_bot    = ov + oht;
  assign dino_right = dh + DW;
  assign dino_bot   = dv + DH;

  // A wrapped obstacle may still look horizontally overlapping; ignore it.
  assign collision = (oh < WRAP_LIMIT) && (obs_left < dino_right) && (oh > dh)
                  && (ov < dino_bot) && (obs_bot > dv);

  assign start_edge = bus.start & ~start_q;
  assign in_run     = (state == ST_RUN);
  assign tick       = in_run && (div == DIV_LAST);
  assign score_inc  = tick && !collision;
  assign score_clr  = start_edge && !in_run;
  assign pass       = in_run && armed && (oh < dh) && !collision;
  assign rearm      = (oh >= SCREEN_LIM) && (oh < WRAP_LIMIT);

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .value (score)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hit        <= 1'b0;
      high_score <= 16'h0000;
      passed     <= 8'd0;
      div        <= 8'd0;
      armed      <= 1'b1;
      start_q    <= 1'b0;
    end else begin
      start_q <= bus.start;
      hit     <= 1'b0;
      if (rearm) begin
        armed <= 1'b1;
      end else if (pass) begin
        armed <= 1'b0;
      end
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state  <= ST_RUN;
            passed <= 8'd0;
            div    <= 8'd0;
          end
        end
        ST_RUN: begin
          if (collision) begin
            state <= ST_OVER;
            hit   <= 1'b1;
            // Packed BCD orders the same as binary, digit by digit from the top.
            if (score > high_score) begin
              high_score <= score;
            end
          end else begin
            div <= tick ? 8'd0 : div + 8'd1;
            if (pass && (passed != 8'hFF)) begin
              passed <= passed + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.game_state       = state;
  assign bus.hit              = hit;
  assign bus.score            = score;
  assign bus.high_score       = high_score;
  assign bus.obstacles_passed = passed;

endmodule

// File: tb/tb_game_monitor.sv
// Scoreboard bench for game_monitor: a default instance plus a SCORE_DIV=1
// instance used to reach score saturation quickly.
module tb_game_monitor;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] OVER = 2'b10;

  typedef struct {
    string       name;
    bit          sel;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] hs;
    logic [7:0]  ps;
    bit          chk_sc;
    bit          chk_ps;
  } exp_t;

  typedef struct {
    string       name;
    bit          sel;
    logic [15:0] sc;
  } hit_t;

  logic clk = 1'b0;
  logic rst;
  bit   sample_req = 1'b0;
  bit   final_req  = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t exp_q[$];
  hit_t hit_q[$];

  game_monitor_if bus_a ();
  game_monitor_if bus_b ();

  game_monitor u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  game_monitor #(.SCORE_DIV(1)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_obs(input bit sel, input int h, input int v, input int w, input int ht);
    if (!sel) begin
      bus_a.obstacle_h = 10'(h); bus_a.obstacle_v = 10'(v);
      bus_a.obstacle_width = 8'(w); bus_a.obstacle_height = 8'(ht);
    end else begin
      bus_b.obstacle_h = 10'(h); bus_b.obstacle_v = 10'(v);
      bus_b.obstacle_width = 8'(w); bus_b.obstacle_height = 8'(ht);
    end
  endtask

  task automatic set_dino(input bit sel, input int h, input int v);
    if (!sel) begin
      bus_a.dino_h = 10'(h); bus_a.dino_v = 10'(v);
    end else begin
      bus_b.dino_h = 10'(h); bus_b.dino_v = 10'(v);
    end
  endtask

  task automatic press(input bit sel);
    if (!sel) bus_a.start = 1'b1; else bus_b.start = 1'b1;
    tick(1);
    if (!sel) bus_a.start = 1'b0; else bus_b.start = 1'b0;
  endtask

  task automatic check(input string name, input bit sel, input logic [1:0] st,
                       input logic [15:0] sc, input logic [15:0] hs, input logic [7:0] ps,
                       input bit chk_sc, input bit chk_ps);
    exp_t e;
    e.name = name; e.sel = sel; e.st = st; e.sc = sc; e.hs = hs; e.ps = ps;
    e.chk_sc = chk_sc; e.chk_ps = chk_ps;
    exp_q.push_back(e);
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req = 1'b0;
  endtask

  task automatic expect_hit(input string name, input bit sel, input logic [15:0] sc);
    hit_t h;
    h.name = name; h.sel = sel; h.sc = sc;
    hit_q.push_back(h);
  endtask

  // Monitor side of the scoreboard
  exp_t        e_cur;
  hit_t        h_cur;
  logic [1:0]  g_st;
  logic [15:0] g_sc, g_hs;
  logic [7:0]  g_ps;
  bit          ok;

  task automatic chk_hit(input bit sel, input logic [1:0] st, input logic [15:0] sc);
    n_cmp++;
    if (hit_q.size() == 0 || hit_q[0].sel != sel) begin
      n_err++;
      $display("FAIL unexpected_hit dut%0d: hit=1 state=%0h score=%h, required hit=0", sel, st, sc);
    end else begin
      h_cur = hit_q.pop_front();
      if (st != OVER || sc != h_cur.sc) begin
        n_err++;
        $display("FAIL %s: at hit state=%0h score=%h, required state=%0h score=%h",
                 h_cur.name, st, sc, OVER, h_cur.sc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sample_req && exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      if (!e_cur.sel) begin
        g_st = bus_a.game_state; g_sc = bus_a.score; g_hs = bus_a.high_score; g_ps = bus_a.obstacles_passed;
      end else begin
        g_st = bus_b.game_state; g_sc = bus_b.score; g_hs = bus_b.high_score; g_ps = bus_b.obstacles_passed;
      end
      ok = (g_st == e_cur.st) && (g_hs == e_cur.hs)
        && (!e_cur.chk_sc || g_sc == e_cur.sc) && (!e_cur.chk_ps || g_ps == e_cur.ps);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL %s: got state=%0h score=%h high=%h passed=%0d, required state=%0h score=%h high=%h passed=%0d",
                 e_cur.name, g_st, g_sc, g_hs, g_ps, e_cur.st, e_cur.sc, e_cur.hs, e_cur.ps);
      end
    end
    if (bus_a.hit) chk_hit(1'b0, bus_a.game_state, bus_a.score);
    if (bus_b.hit) chk_hit(1'b1, bus_b.game_state, bus_b.score);
    if (final_req) begin
      n_cmp++;
      if (hit_q.size() != 0) begin
        n_err++;
        $display("FAIL missing_hit: %0d expected hit pulses never seen, required 0 (first %s)",
                 hit_q.size(), hit_q[0].name);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    set_obs(0, 1020, 360, 30, 80); set_dino(0, 100, 397);
    set_obs(1, 1020, 360, 30, 80); set_dino(1, 100, 397);
    tick(3);
    rst = 1'b0;
    check("reset_a", 0, IDLE, 16'h0000, 16'h0000, 8'd0, 1, 1);

    // First run: start, score progression, collision
    press(0);
    check("run_start", 0, RUN, 16'h0000, 16'h0000, 8'd0, 1, 1);
    tick(80);
    check("score_80", 0, RUN, 16'h0010, 16'h0000, 8'd0, 1, 1);
    expect_hit("hit_run1", 0, 16'h0010);
    set_obs(0, 150, 360, 30, 80);
    tick(1);
    check("collide_run1", 0, OVER, 16'h0010, 16'h0010, 8'd0, 1, 1);
    tick(20);
    check("over_frozen", 0, OVER, 16'h0010, 16'h0010, 8'd0, 1, 1);

    // Second run: wrapped obstacle ignored, edge of wrap region collides
    set_obs(0, 1020, 360, 30, 80);
    press(0);
    check("restart1", 0, RUN, 16'h0000, 16'h0010, 8'd0, 1, 1);
    set_dino(0, 500, 397);
    set_obs(0, 720, 360, 255, 80);
    tick(10);
    check("wrapped_no_hit", 0, RUN, 16'h0001, 16'h0010, 8'd0, 1, 1);
    expect_hit("hit_703", 0, 16'h0001);
    set_obs(0, 703, 360, 255, 80);
    tick(1);
    check("collide_703", 0, OVER, 16'h0001, 16'h0010, 8'd0, 1, 1);

    // Third run: obstacle pass counting, disarm and re-arm
    set_dino(0, 100, 397);
    set_obs(0, 670, 300, 30, 40);
    press(0);
    check("restart2", 0, RUN, 16'h0000, 16'h0010, 8'd0, 1, 1);
    for (int h = 650; h >= 50; h -= 20) begin
      set_obs(0, h, 300, 30, 40);
      tick(1);
    end
    check("pass_1", 0, RUN, 16'h0000, 16'h0010, 8'd1, 0, 1);
    tick(5);
    check("pass_hold", 0, RUN, 16'h0000, 16'h0010, 8'd1, 0, 1);
    for (int h = 670; h >= 50; h -= 20) begin
      set_obs(0, h, 300, 30, 40);
      tick(1);
    end
    check("pass_2", 0, RUN, 16'h0000, 16'h0010, 8'd2, 0, 1);
    set_obs(0, 710, 300, 30, 40);
    tick(1);
    for (int h = 630; h >= 50; h -= 20) begin
      set_obs(0, h, 300, 30, 40);
      tick(1);
    end
    check("no_rearm_704", 0, RUN, 16'h0000, 16'h0010, 8'd2, 0, 1);
    // 99 clocks into this run: score 12, divider at 3
    expect_hit("hit_run3", 0, 16'h0012);
    set_obs(0, 150, 360, 30, 80);
    tick(1);
    check("collide_run3", 0, OVER, 16'h0012, 16'h0012, 8'd2, 1, 1);

    // Fourth run: collision lands on the divider wrap
    set_obs(0, 1020, 360, 30, 80);
    press(0);
    tick(7);
    expect_hit("hit_wrap", 0, 16'h0000);
    set_obs(0, 150, 360, 30, 80);
    tick(1);
    check("collide_on_wrap", 0, OVER, 16'h0000, 16'h0012, 8'd0, 1, 1);

    // Fast instance: saturation and high score 9999
    press(1);
    check("b_start", 1, RUN, 16'h0000, 16'h0000, 8'd0, 1, 1);
    tick(100);
    check("b_score_100", 1, RUN, 16'h0100, 16'h0000, 8'd0, 1, 1);
    tick(9898);
    check("b_score_9998", 1, RUN, 16'h9998, 16'h0000, 8'd0, 1, 1);
    tick(5);
    check("b_saturate", 1, RUN, 16'h9999, 16'h0000, 8'd0, 1, 1);
    expect_hit("hit_b", 1, 16'h9999);
    set_obs(1, 150, 360, 30, 80);
    tick(1);
    check("b_collide", 1, OVER, 16'h9999, 16'h9999, 8'd0, 1, 1);
    set_obs(1, 1020, 360, 30, 80);
    press(1);
    check("b_restart", 1, RUN, 16'h0000, 16'h9999, 8'd0, 1, 1);

    // Reset in the middle of a run
    set_obs(0, 1020, 360, 30, 80);
    press(0);
    tick(20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_run_a", 0, IDLE, 16'h0000, 16'h0000, 8'd0, 1, 1);
    check("rst_mid_run_b", 1, IDLE, 16'h0000, 16'h0000, 8'd0, 1, 1);

    tick(3);
    final_req = 1'b1;
    @(negedge clk);
    #1;
    final_req = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_monitor.md
GAME_MONITOR -- requirements
Module: game_monitor

Interface
REQ-001 Parameter SCREEN_WIDTH, default 640, is the horizontal pixel extent; obstacle_h >= SCREEN_WIDTH+64 SHALL be treated as wrapped/off-screen.
REQ-002 Parameter DINO_WIDTH, default 40, is the dino bounding-box width in pixels.
REQ-003 Parameter DINO_HEIGHT, default 43, is the dino bounding-box height in pixels.
REQ-004 Parameter SCORE_DIV, default 8, is the number of clk cycles per score point while running (range 1..255).
REQ-005 clk  input  1  game frame clock; all state changes on its rising edge; single clock domain.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  player start/restart button, level-sensitive, already debounced.
REQ-008 obstacle_h  input  10  obstacle x reference, upper-right corner.
REQ-009 obstacle_v  input  10  obstacle y reference, upper edge.
REQ-010 obstacle_width  input  8  obstacle width in pixels.
REQ-011 obstacle_height  input  8  obstacle height in pixels.
REQ-012 dino_h  input  10  dino x, upper-left corner.
REQ-013 dino_v  input  10  dino y, upper edge.
REQ-014 game_state  output  2  00 IDLE, 01 RUN, 10 OVER.
REQ-015 hit  output  1  one-cycle pulse on collision.
REQ-016 score  output  16  current score, 4 BCD digits.
REQ-017 high_score  output  16  best score since reset, 4 BCD digits.
REQ-018 obstacles_passed  output  8  count of obstacles cleared in the current run, binary.

Function
REQ-019 Collision SHALL be obs_left < dino_h+DINO_WIDTH AND obstacle_h > dino_h AND obstacle_v < dino_v+DINO_HEIGHT AND obstacle_v+obstacle_height > dino_v, where obs_left = obstacle_h-obstacle_width; all arithmetic is 11-bit unsigned and obs_left is clamped to 0 when obstacle_width > obstacle_h.
REQ-020 Collision SHALL be forced false when obstacle_h >= SCREEN_WIDTH+64.
REQ-021 start_edge SHALL be start high this cycle and low in the previous registered sample.
REQ-022 IDLE transitions to RUN on start_edge, with score, obstacles_passed and the divider cleared at that edge.
REQ-023 RUN transitions to OVER on the edge where collision is true; hit SHALL be 1 for exactly the following cycle.
REQ-024 OVER SHALL hold score; on start_edge it transitions to RUN, clearing score, obstacles_passed and the divider.
REQ-025 In RUN the divider counts 0..SCORE_DIV-1; score increments by 1 (BCD) on the cycle the divider wraps.
REQ-026 Score SHALL saturate at 9999; further ticks are ignored.
REQ-027 A pass SHALL be counted once per obstacle when obstacle_h < dino_h while armed; counting disarms; re-arm occurs when obstacle_h >= SCREEN_WIDTH and < SCREEN_WIDTH+64.
REQ-028 obstacles_passed SHALL saturate at 255.
REQ-029 On a cycle with both collision and score tick or pass, collision wins: no increment, and the state goes to OVER.
REQ-030 On the RUN->OVER edge, high_score SHALL load score if score > high_score (BCD compare equals binary compare digit-wise from MSD).
REQ-031 Outside RUN, score, divider and obstacles_passed SHALL not change except for the clears in REQ-022/024.

Reset
REQ-032 rst SHALL have priority over all other inputs and take effect on the next rising clk edge.
REQ-033 Reset values: game_state IDLE, hit 0, score 0x0000, high_score 0x0000, obstacles_passed 0, divider 0, armed 1, start sample 0.
REQ-034 rst asserted mid-RUN SHALL discard the current score without updating high_score.

Structure
REQ-035 Package dino_pkg SHALL hold the game_state encoding, SCREEN_WIDTH, ground line 440 and the dino dimension constants.
REQ-036 The 4-digit saturating BCD incrementer SHALL be a sub-module bcd_counter4 (clk, rst, clr, inc, value[15:0]).

Verification
REQ-037 rst, then start pulse -> game_state 01 the next cycle; score 0x0000; after 80 cycles with no collision, score 0x0010.
REQ-038 In RUN, dino (100,397), obstacle h=150 v=360 w=30 h=80 -> game_state 10 and hit=1 for exactly one cycle; score frozen.
REQ-039 In RUN, obstacle_h=1020 (wrapped) with overlapping v -> no hit; obstacle_h sweeps from 670 down past 100 -> obstacles_passed +1 once.
REQ-040 Preload score near 9999 via a long run (SCORE_DIV=1) -> score holds at 0x9999; collision -> high_score 0x9999; restart -> score 0x0000, high_score kept.
REQ-041 Collision and divider wrap on the same cycle -> score unchanged, state OVER; rst mid-RUN -> all outputs match REQ-033.
